// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Handshaked execution unit; single-cycle ALU ops, bit-serial shifts.
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ALUControl,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;

    logic                 w_is_shift;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_alu;
    logic [WIDTH-1:0]     w_step;

    assign w_is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                        (ALUControl == OP_SRA);
    assign w_shamt    = SrcB[SHAMT_W-1:0];

    // Shift codes fall through to SrcA: that is the shamt==0 result.
    always_comb begin
        w_alu = SrcA;
        case (ALUControl)
            OP_ADD:  w_alu = SrcA + SrcB;
            OP_SUB:  w_alu = SrcA - SrcB;
            OP_AND:  w_alu = SrcA & SrcB;
            OP_OR:   w_alu = SrcA | SrcB;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: w_alu = SrcA;
        endcase
    end

    always_comb begin
        w_step = work_q;
        case (op_q)
            OP_SLL:  w_step = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  w_step = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  w_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: w_step = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        work_d  = SrcA;
                        cnt_d   = w_shamt;
                        op_d    = ALUControl;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = w_alu;
                        zero_d   = (w_alu == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_d = w_step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = w_step;
                    zero_d   = (w_step == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Randomized and directed bench for alu_exec_unit against a reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ALUControl = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: return a << sh;
            3'd6: return a >> sh;
            default: return 32'($signed(a) >>> sh);
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd4 || op == 3'd6 || op == 3'd7) return int'(b[4:0]);
        return 0;
    endfunction

    // Model: idle / waiting N edges / presenting a result, plus the last result.
    bit          m_idle = 1'b1;
    bit          m_out  = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_out = 1'b0; m_wait = 0; m_res = '0;
        end
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_idle});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_out});
        chk("busy",      {31'd0, busy},      {31'd0, !m_idle});
        chk("ALUResult", ALUResult, m_res);
        chk("Zero",      {31'd0, Zero},      {31'd0, (m_res == 32'd0)});
        if (rst_n) begin
            if (m_idle) begin
                if (in_valid) begin
                    m_idle = 1'b0;
                    m_wait = ref_lat(ALUControl, SrcB);
                    m_pend = ref_res(ALUControl, SrcA, SrcB);
                    if (m_wait == 0) begin m_out = 1'b1; m_res = m_pend; end
                end
            end else if (!m_out) begin
                m_wait--;
                if (m_wait == 0) begin m_out = 1'b1; m_res = m_pend; end
            end else if (out_ready) begin
                m_out = 1'b0; m_idle = 1'b1;
            end
        end
    end

    // Issues one op; optionally backpressures for 'hold' cycles and presents a
    // follow-up request during the stall.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit pre, input logic [2:0] nop,
                          input logic [31:0] na, input logic [31:0] nb,
                          output logic [31:0] res, output logic z, output int lat);
        bit ok;
        res = 'x; z = 1'bx; lat = -1;
        in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
        out_ready = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin chk("accept_timeout", 32'd0, 32'd1); in_valid = 1'b0; return; end
        @(posedge clk); #1;
        in_valid = 1'b0; ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; lat = i; break; end
        end
        if (!ok) begin chk("result_timeout", 32'd0, 32'd1); return; end
        res = ALUResult; z = Zero;
        if (hold > 0) begin
            if (pre) begin in_valid = 1'b1; ALUControl = nop; SrcA = na; SrcB = nb; end
            repeat (hold) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [31:0] r;
    logic        z;
    int          lat;

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, r, z, lat);
        chk("add_wrap", r, 32'h0); chk("add_zero", {31'd0, z}, 32'd1); chk("add_lat", lat, 0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, r, z, lat);
        chk("sub", r, 32'hFFFF_FFFE); chk("sub_zero", {31'd0, z}, 32'd0);
        run_op(3'b101, 32'h8000_0000, 32'd1, 0, 0, 0, 0, 0, r, z, lat);
        chk("slt_neg", r, 32'd1);
        run_op(3'b101, 32'd1, 32'h8000_0000, 0, 0, 0, 0, 0, r, z, lat);
        chk("slt_pos", r, 32'd0);
        run_op(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 0, r, z, lat);
        chk("and", r, 32'h00F0_00F0);
        run_op(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 0, r, z, lat);
        chk("or", r, 32'hFFF0_FFF0);
        run_op(3'b111, 32'h8000_0001, 32'd4, 0, 0, 0, 0, 0, r, z, lat);
        chk("sra", r, 32'hF800_0000); chk("sra_lat", lat, 4);
        run_op(3'b110, 32'h8000_0001, 32'd4, 0, 0, 0, 0, 0, r, z, lat);
        chk("srl", r, 32'h0800_0000); chk("srl_lat", lat, 4);
        run_op(3'b100, 32'h8000_0001, 32'd4, 0, 0, 0, 0, 0, r, z, lat);
        chk("sll", r, 32'h0000_0010);
        run_op(3'b111, 32'h8000_0001, 32'd0, 0, 0, 0, 0, 0, r, z, lat);
        chk("shamt0", r, 32'h8000_0001); chk("shamt0_lat", lat, 0);

        // Backpressure with a follow-up request waiting during the stall
        run_op(3'b000, 32'd7, 32'd9, 6, 1, 3'b001, 32'd20, 32'd5, r, z, lat);
        chk("bp_add", r, 32'd16);
        run_op(3'b001, 32'd20, 32'd5, 0, 0, 0, 0, 0, r, z, lat);
        chk("bp_next", r, 32'd15);

        // Asynchronous reset in the middle of a long shift
        in_valid = 1'b1; ALUControl = 3'b100; SrcA = 32'd1; SrcB = 32'd31;
        @(negedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(3'b000, 32'd2, 32'd3, 0, 0, 0, 0, 0, r, z, lat);
        chk("post_rst_add", r, 32'd5); chk("post_rst_lat", lat, 0);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          h;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            h  = $urandom_range(0, 2);
            run_op(op, a, b, h, 0, 0, 0, 0, r, z, lat);
            chk("rand_res", r, ref_res(op, a, b));
            chk("rand_lat", lat, ref_lat(op, b));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
